// File: rtl/loop_iter_ctrl_group_pkg.sv
// Shared mem-walker definitions: default widths, controller FSM states, iter_done bit meanings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package loop_iter_ctrl_group_pkg;

   localparam int LOOP_ID_W_DEF  = 5;
   localparam int GROUP_ID_W_DEF = 2;
   localparam int ITER_W_DEF     = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } loop_state_e;

   // iter_done bit 0 doubles as "whole nest finished" once DONE is reached.
   localparam int IDX_ALL_DONE = 0;

   // Strobe bit sits just above the innermost loop bit.
   function automatic int idx_step(input int loop_id_w);
      return 1 << loop_id_w;
   endfunction

endpackage

// File: rtl/loop_iter_cfg_table.sv
// Per-group loop iteration-count table with saturating per-group write pointers.
// Latency: write lands on the next clk edge; read port is combinational.
// Backpressure: none; writes to a full group are silently dropped.
//
// Ports: clk, reset (sync, active-high), clear (zeroes write pointers only),
//        wr_vld/wr_dat/wr_group_id (append one count), rd_group_id -> rd_max (all loops of a group).
module loop_iter_cfg_table
   import loop_iter_ctrl_group_pkg::*;
#(
   parameter int LOOP_ID_W  = LOOP_ID_W_DEF,
   parameter int GROUP_ID_W = GROUP_ID_W_DEF,
   parameter int ITER_W     = ITER_W_DEF,
   localparam int NUM_MAX_LOOPS  = 1 << LOOP_ID_W,
   localparam int NUM_MAX_GROUPS = 1 << GROUP_ID_W
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   clear,
   input  logic                                   wr_vld,
   input  logic [ITER_W-1:0]                      wr_dat,
   input  logic [GROUP_ID_W-1:0]                  wr_group_id,
   input  logic [GROUP_ID_W-1:0]                  rd_group_id,
   output logic [NUM_MAX_LOOPS-1:0][ITER_W-1:0]   rd_max
);

   localparam logic [LOOP_ID_W:0] WP_FULL = (LOOP_ID_W + 1)'(NUM_MAX_LOOPS);

   logic [NUM_MAX_GROUPS-1:0][NUM_MAX_LOOPS-1:0][ITER_W-1:0] max_tbl;
   // One extra bit so the pointer can rest at NUM_MAX_LOOPS (full).
   logic [NUM_MAX_GROUPS-1:0][LOOP_ID_W:0]                   wp;

   always_ff @(posedge clk) begin
      if (reset) begin
         max_tbl <= '0;
         wp      <= '0;
      end else if (clear) begin
         // Table contents survive; only the append position restarts.
         wp <= '0;
      end else if (wr_vld && (wp[wr_group_id] != WP_FULL)) begin
         max_tbl[wr_group_id][wp[wr_group_id][LOOP_ID_W-1:0]] <= wr_dat;
         wp[wr_group_id] <= wp[wr_group_id] + 1'b1;
      end
   end

   assign rd_max = max_tbl[rd_group_id];

endmodule

// File: rtl/loop_iter_ctrl_group.sv
// Nested-loop iteration controller: steps a per-group counter nest and drives iter_done to the walkers.
// Latency: iter_done for a step is combinational in the same cycle; done pulses one cycle after the final wrap.
// Backpressure: stall (or start / group switch) suppresses the step; counters and state hold.
//
// Ports: clk, reset (sync, active-high), start, block_done, stall,
//        cfg_loop_iter_v/cfg_loop_iter/cfg_loop_group_id (table append), loop_group_id (executing group),
//        iter_done[NUM_MAX_LOOPS:0], step_v (= strobe bit), busy (RUN), done (pulse on DONE entry).
module loop_iter_ctrl_group
   import loop_iter_ctrl_group_pkg::*;
#(
   parameter int LOOP_ID_W     = LOOP_ID_W_DEF,
   parameter int GROUP_ID_W    = GROUP_ID_W_DEF,
   parameter int ITER_W        = ITER_W_DEF,
   parameter int GROUP_ENABLED = 1,
   localparam int NUM_MAX_LOOPS  = 1 << LOOP_ID_W,
   localparam int NUM_MAX_GROUPS = 1 << GROUP_ID_W
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      block_done,
   input  logic                      stall,
   input  logic                      cfg_loop_iter_v,
   input  logic [ITER_W-1:0]         cfg_loop_iter,
   input  logic [GROUP_ID_W-1:0]     cfg_loop_group_id,
   input  logic [GROUP_ID_W-1:0]     loop_group_id,
   output logic [NUM_MAX_LOOPS:0]    iter_done,
   output logic                      step_v,
   output logic                      busy,
   output logic                      done
);

   localparam int IDX_STEP = idx_step(LOOP_ID_W);

   loop_state_e state, state_nxt;

   logic [GROUP_ID_W-1:0]                                    grp, cfg_grp, prev_grp;
   logic                                                     load_new_group;
   logic                                                     step;
   logic [NUM_MAX_LOOPS:0]                                   wrap;
   logic [NUM_MAX_LOOPS-1:0][ITER_W-1:0]                     cnt;
   logic [NUM_MAX_LOOPS-1:0][ITER_W-1:0]                     cur_max;
   logic [NUM_MAX_GROUPS-1:0][NUM_MAX_LOOPS-1:0][ITER_W-1:0] sav;

   // With grouping disabled every request collapses onto group 0.
   assign grp     = (GROUP_ENABLED != 0) ? loop_group_id     : '0;
   assign cfg_grp = (GROUP_ENABLED != 0) ? cfg_loop_group_id : '0;

   assign load_new_group = (grp != prev_grp);
   assign step = (state == RUN) && !stall && !start && !load_new_group;

   loop_iter_cfg_table #(
      .LOOP_ID_W  (LOOP_ID_W),
      .GROUP_ID_W (GROUP_ID_W),
      .ITER_W     (ITER_W)
   ) u_cfg_table (
      .clk         (clk),
      .reset       (reset),
      .clear       (block_done),
      .wr_vld      (cfg_loop_iter_v),
      .wr_dat      (cfg_loop_iter),
      .wr_group_id (cfg_grp),
      .rd_group_id (grp),
      .rd_max      (cur_max)
   );

   // Wrap ripples from the strobe (innermost side) outward; a running AND
   // keeps wrap write-only so the chain is not a self-referencing net.
   always_comb begin
      logic acc;
      wrap = '0;
      acc  = step;
      wrap[NUM_MAX_LOOPS] = acc;
      for (int i = NUM_MAX_LOOPS - 1; i >= 0; i--) begin
         acc     = acc && (cnt[i] == cur_max[i]);
         wrap[i] = acc;
      end
   end

   always_comb begin
      state_nxt = state;
      if (block_done && (state != IDLE)) begin
         state_nxt = IDLE;
      end else if (start) begin
         state_nxt = RUN;
      end else if (wrap[0]) begin
         state_nxt = DONE;
      end
   end

   always_comb begin
      iter_done = '0;
      unique case (state)
         RUN:     iter_done = wrap;
         DONE:    iter_done[IDX_ALL_DONE] = 1'b1;
         default: iter_done = '0;
      endcase
   end

   assign step_v = iter_done[IDX_STEP];
   assign busy   = (state == RUN);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         sav      <= '0;
         prev_grp <= '0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         prev_grp <= grp;
         // wrap[0] only rises on a RUN step, so this marks DONE entry.
         done     <= wrap[0];

         if (load_new_group) begin
            sav[prev_grp] <= cnt;
         end
         // Later assignment wins: block_done discards any same-cycle save.
         if (block_done) begin
            sav <= '0;
         end

         if (start) begin
            cnt <= '0;
         end else if (load_new_group) begin
            cnt <= sav[grp];
         end else begin
            for (int i = 0; i < NUM_MAX_LOOPS; i++) begin
               if (wrap[i]) begin
                  cnt[i] <= '0;
               end else if (wrap[i+1]) begin
                  cnt[i] <= cnt[i] + 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_loop_iter_ctrl_group.sv
module tb_loop_iter_ctrl_group;

   localparam int NL = 32;
   localparam int NG = 4;
   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_DONE = 2;
   localparam longint CAP = 64'sd1 << 40;

   logic          clk = 1'b0;
   logic          reset, start, block_done, stall, cfg_loop_iter_v;
   logic [15:0]   cfg_loop_iter;
   logic [1:0]    cfg_loop_group_id, loop_group_id;
   logic [NL:0]   iter_done;
   logic          step_v, busy, done;

   loop_iter_ctrl_group dut (
      .clk               (clk),
      .reset             (reset),
      .start             (start),
      .block_done        (block_done),
      .stall             (stall),
      .cfg_loop_iter_v   (cfg_loop_iter_v),
      .cfg_loop_iter     (cfg_loop_iter),
      .cfg_loop_group_id (cfg_loop_group_id),
      .loop_group_id     (loop_group_id),
      .iter_done         (iter_done),
      .step_v            (step_v),
      .busy              (busy),
      .done              (done)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: each group's nest is a single linear progress count;
   // loop i wraps whenever (progress+1) is a multiple of the product of the
   // trip counts of loops i..innermost.
   int      mstate;
   longint  pos[NG];
   int      prev_g;
   int      mx[NG][NL];
   int      wp[NG];
   bit      done_q;
   int      cur_g;

   logic [NL:0] o_id;
   logic        o_step, o_busy, o_done;

   function automatic longint stride(input int g, input int i);
      longint p = 1;
      for (int j = i; j < NL; j++) begin
         p = p * longint'(mx[g][j] + 1);
         if (p > CAP) p = CAP;
      end
      return p;
   endfunction

   task automatic reset_model();
      mstate = M_IDLE;
      prev_g = 0;
      done_q = 1'b0;
      for (int g = 0; g < NG; g++) begin
         pos[g] = 0;
         wp[g]  = 0;
         for (int l = 0; l < NL; l++) mx[g][l] = 0;
      end
   endtask

   // One clock: drive at negedge, check just after, advance model, wait next negedge.
   task automatic cyc(input bit rst, input bit st, input bit bd, input bit stl,
                      input bit cv, input int cval, input int cg);
      logic [NL:0] e_id;
      bit sw, stp, fin;
      int g;
      reset = rst; start = st; block_done = bd; stall = stl;
      cfg_loop_iter_v = cv; cfg_loop_iter = 16'(cval);
      cfg_loop_group_id = 2'(cg); loop_group_id = 2'(cur_g);
      #1;
      g   = cur_g;
      sw  = (g != prev_g);
      stp = (mstate == M_RUN) && !stl && !st && !sw;
      e_id = '0;
      if (mstate == M_RUN) begin
         e_id[NL] = stp;
         if (stp) for (int i = 0; i < NL; i++) e_id[i] = ((pos[g] + 1) % stride(g, i)) == 0;
      end else if (mstate == M_DONE) begin
         e_id[0] = 1'b1;
      end
      o_id = iter_done; o_step = step_v; o_busy = busy; o_done = done;
      chk_eq("iter_done", 64'(iter_done), 64'(e_id));
      chk_eq("step_v", 64'(step_v), 64'(e_id[NL]));
      chk_eq("busy", 64'(busy), 64'(mstate == M_RUN));
      chk_eq("done", 64'(done), 64'(done_q));
      if (rst) begin
         reset_model();
      end else begin
         fin = stp && (((pos[g] + 1) % stride(g, 0)) == 0);
         if (bd && mstate != M_IDLE) mstate = M_IDLE;
         else if (st) mstate = M_RUN;
         else if (fin) mstate = M_DONE;
         done_q = fin;
         if (st) pos[g] = 0;
         else if (stp) pos[g] = fin ? 0 : pos[g] + 1;
         if (bd) begin
            for (int k = 0; k < NG; k++) begin
               if (k != g) pos[k] = 0;
               wp[k] = 0;
            end
         end else if (cv && wp[cg] < NL) begin
            mx[cg][wp[cg]] = cval;
            wp[cg]++;
         end
         prev_g = g;
      end
      @(negedge clk);
   endtask

   task automatic tick(input bit st, input bit stl);
      cyc(1'b0, st, 1'b0, stl, 1'b0, 0, 0);
   endtask

   task automatic wr(input int g, input int v);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, v, g);
   endtask

   task automatic bdone();
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
   endtask

   task automatic fill(input int g, input int a0, input int a30, input int a31);
      wr(g, a0);
      for (int i = 1; i < 30; i++) wr(g, 0);
      wr(g, a30);
      wr(g, a31);
   endtask

   // Runs until the done pulse (bounded); stall held for RUN cycles s_lo..s_hi.
   task automatic run(input int s_lo, input int s_hi, output int steps,
                      output int bcyc, output int dones, output int b31);
      steps = 0; bcyc = 0; dones = 0; b31 = 0;
      for (int k = 0; k < 64; k++) begin
         tick(1'b0, (k >= s_lo) && (k <= s_hi));
         steps += int'(o_step);
         bcyc  += int'(o_busy);
         dones += int'(o_done);
         b31   += int'(o_id[31]);
         if (o_done) break;
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s, b, d, b31;
      reset = 1'b1; start = 1'b0; block_done = 1'b0; stall = 1'b0;
      cfg_loop_iter_v = 1'b0; cfg_loop_iter = '0; cfg_loop_group_id = '0; loop_group_id = '0;
      cur_g = 0;
      reset_model();
      repeat (2) @(posedge clk);
      @(negedge clk);

      // Basic 2x3 nest on group 0.
      bdone();
      fill(0, 0, 1, 2);
      tick(1'b1, 1'b0);
      run(-1, -1, s, b, d, b31);
      chk_eq("s1_steps", 64'(s), 64'd6);
      chk_eq("s1_busy_cycles", 64'(b), 64'd6);
      chk_eq("s1_done_pulses", 64'(d), 64'd1);
      chk_eq("s1_bit31_count", 64'(b31), 64'd2);
      tick(1'b0, 1'b0);
      chk_eq("s1_done_once", 64'(o_done), 64'd0);
      chk_eq("s1_done_vector", 64'(o_id), 64'd1);

      // Same nest with two stalled cycles.
      tick(1'b1, 1'b0);
      run(2, 3, s, b, d, b31);
      chk_eq("s2_busy_cycles", 64'(b), 64'd8);
      chk_eq("s2_steps", 64'(s), 64'd6);
      chk_eq("s2_bit31_count", 64'(b31), 64'd2);

      // Group switch mid-nest and resume.
      fill(1, 0, 0, 3);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      cur_g = 1;
      tick(1'b0, 1'b0);
      chk_eq("s3_switch_no_step", 64'(o_step), 64'd0);
      repeat (3) tick(1'b0, 1'b0);
      cur_g = 0;
      tick(1'b0, 1'b0);
      run(-1, -1, s, b, d, b31);
      chk_eq("s3_resume_steps", 64'(s), 64'd4);

      // Write-pointer saturation and block_done pointer reset on group 2.
      bdone();
      for (int i = 0; i < 30; i++) wr(2, 0);
      wr(2, 1);
      wr(2, 2);
      wr(2, 5);
      cur_g = 2;
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      run(-1, -1, s, b, d, b31);
      chk_eq("s4_sat_steps", 64'(s), 64'd6);
      bdone();
      wr(2, 1);
      tick(1'b1, 1'b0);
      run(-1, -1, s, b, d, b31);
      chk_eq("s4_rewrite_steps", 64'(s), 64'd12);

      // Restart in RUN cycle 3.
      cur_g = 0;
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      repeat (3) tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      run(-1, -1, s, b, d, b31);
      chk_eq("s5_restart_steps", 64'(s), 64'd6);

      // Reset mid-RUN clears state and tables.
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      tick(1'b0, 1'b0);
      chk_eq("s6_iter_done", 64'(o_id), 64'd0);
      chk_eq("s6_busy", 64'(o_busy), 64'd0);
      tick(1'b1, 1'b0);
      run(-1, -1, s, b, d, b31);
      chk_eq("s6_zero_table_steps", 64'(s), 64'd1);

      // Randomized episodes against the model.
      for (int e = 0; e < 25; e++) begin
         int n;
         bdone();
         n = $urandom_range(40, 0);
         for (int w = 0; w < n; w++)
            wr($urandom_range(3, 0), ($urandom_range(7, 0) == 0) ? $urandom_range(3, 1) : 0);
         tick(1'b1, 1'b0);
         for (int c = 0; c < 80; c++) begin
            if ($urandom_range(9, 0) == 0) cur_g = $urandom_range(3, 0);
            tick($urandom_range(29, 0) == 0, $urandom_range(3, 0) == 0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/loop_iter_ctrl_group.md
Name: loop_iter_ctrl_group

Overview:
Nested-loop iteration controller that sits directly upstream of the stride-group memory walkers. It holds per-group, per-loop iteration counts from the instruction decoder and steps a counter nest once per un-stalled cycle. It drives the shared iter_done vector that every walker of a tile consumes. Loop 0 is outermost, loop NUM_MAX_LOOPS-1 is innermost, and bit NUM_MAX_LOOPS is the per-step strobe.

Parameters:
LOOP_ID_W, 5, loop index width
GROUP_ID_W, 2, group index width
ITER_W, 16, iteration-count width
GROUP_ENABLED, 1, 0 forces all group ids to 0
NUM_MAX_LOOPS, 1<<LOOP_ID_W, loop slots
NUM_MAX_GROUPS, 1<<GROUP_ID_W, group slots

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  pulse: begin the nest for the current group
block_done  in  1  pulse: end of instruction block; clears config pointers and saved state
stall  in  1  hold counters; no step this cycle
cfg_loop_iter_v  in  1  config write strobe
cfg_loop_iter  in  ITER_W  iteration count minus 1 for the next loop slot
cfg_loop_group_id  in  GROUP_ID_W  group the config write targets
loop_group_id  in  GROUP_ID_W  group currently executing
iter_done  out  NUM_MAX_LOOPS+1  wrap vector to walkers
step_v  out  1  equals iter_done[NUM_MAX_LOOPS]
busy  out  1  state==RUN
done  out  1  one-cycle pulse on the cycle DONE is entered

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: state IDLE, all counters 0, all iteration tables 0, all write pointers 0, saved counters 0, iter_done 0, busy 0, done 0.
- Config:
  - Per-group write pointer wp[g].
  - On cfg_loop_iter_v, write max[g][wp[g]] <= cfg_loop_iter and increment wp[g], where g = cfg_loop_group_id.
  - Writes while wp[g] == NUM_MAX_LOOPS are ignored; the pointer saturates.
  - block_done zeroes all wp and all saved counters and takes priority over a same-cycle cfg write.
  - Unwritten slots keep max = 0, so they act as single-iteration loops that wrap on every step (transparent to the walker).
- FSM transitions:
  - IDLE -start-> RUN.
  - RUN -final wrap-> DONE.
  - DONE -start-> RUN.
  - start in any state zeroes the current group's counters and enters RUN.
  - block_done in RUN or DONE returns to IDLE.
- Step: step = (state==RUN) && ~stall && ~start && ~load_new_group.
- Wrap chain (combinational):
  - wrap[NUM_MAX_LOOPS] = step.
  - wrap[i] = wrap[i+1] && cnt[i]==max[grp][i].
- iter_done is combinational from the current counters:
  - In RUN: iter_done[i] = wrap[i].
  - In DONE: iter_done[0] = 1 and all other bits 0.
  - In IDLE: all bits 0.
- Counter update on the clock edge, per loop i:
  - wrap[i]: cnt[i] <= 0.
  - else wrap[i+1]: cnt[i] <= cnt[i]+1.
  - else: hold.
- Final wrap: wrap[0] is asserted on the last step. The next state is DONE, and done pulses one cycle later.
- Group switch:
  - load_new_group = loop_group_id != registered previous id.
  - On a switch, the live counters are saved to sav[prev] and restored from sav[new]; no step occurs that cycle.
  - Switching while in DONE keeps DONE.
- Stall: counters, state and iter_done all hold with no step. iter_done reflects the held state, with strobe bits 0.
- Width: counters are ITER_W bits. cnt never exceeds max, so no overflow is possible.
- Latency: iter_done for step n is asserted in the same cycle as step n.
- Reset mid-RUN: immediately returns to the reset values listed above.

Decomposition:
- Shared package (mem-walker package) holds:
  - LOOP_ID_W, GROUP_ID_W and ITER_W defaults.
  - The FSM state typedef {IDLE, RUN, DONE}.
  - The iter_done bit-meaning constants: IDX_ALL_DONE = 0, IDX_STEP = NUM_MAX_LOOPS.
- One sub-module, loop_iter_cfg_table: per-group write pointers plus the max[g][l] storage, with a read port indexed by loop_group_id.

Test Plan:
- Config group 0 loops 30/31 (innermost two) = 1, 2, then start, no stall → 6 steps. iter_done[32] high in cycles 0–5; iter_done[31] high in cycles 2 and 5; iter_done[30..0] high in cycle 5; DONE from cycle 6 with iter_done = 1 and done pulsing once.
- Same config with stall high in cycles 2–3 → total of 8 RUN cycles; iter_done[31] fires on the 3rd and 6th un-stalled steps only.
- Groups 0 and 1 configured differently. Switch loop_group_id 0→1 mid-nest (after 2 steps), run 3 steps, switch back → group 0 resumes at count 2 and finishes after exactly 4 further steps.
- 33 cfg writes to group 2 → wp saturates at 32, table unchanged by the 33rd write; block_done then resets wp to 0.
- start asserted in cycle 3 of RUN → counters zero, nest restarts, full 6-step pattern repeats.
- reset asserted mid-RUN → next cycle iter_done = 0, busy = 0, and every max readback = 0.
